// File: rtl/wr_beat_seq.sv
// wr_beat_seq: splits one wide write request into narrow bus beats.
// Only windows with a non-zero byte-enable are issued, lowest address first,
// with one beat outstanding at a time and each beat waiting for its response.
// Per-beat errors are OR-ed and reported with the one-cycle o_done pulse.
module wr_beat_seq #(
  parameter int unsigned IN_P_DW_BYTES  = 3,
  parameter int unsigned OUT_P_DW_BYTES = 2,
  parameter int unsigned AW             = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_req_vld,
  output logic                             o_req_rdy,
  input  logic [AW-1:0]                    i_req_addr,
  input  logic [(1<<IN_P_DW_BYTES)*8-1:0]  i_req_dat,
  input  logic [(1<<IN_P_DW_BYTES)-1:0]    i_req_be,
  output logic                             o_bus_vld,
  input  logic                             i_bus_rdy,
  output logic [AW-1:0]                    o_bus_addr,
  output logic [(1<<OUT_P_DW_BYTES)*8-1:0] o_bus_dat,
  output logic [(1<<OUT_P_DW_BYTES)-1:0]   o_bus_be,
  input  logic                             i_bus_bvld,
  input  logic                             i_bus_berr,
  output logic                             o_done,
  output logic                             o_err
);

  localparam int unsigned IN_DW  = (1 << IN_P_DW_BYTES) * 8;
  localparam int unsigned IN_BE  = 1 << IN_P_DW_BYTES;
  localparam int unsigned OUT_DW = (1 << OUT_P_DW_BYTES) * 8;
  localparam int unsigned OUT_BE = 1 << OUT_P_DW_BYTES;
  localparam int unsigned N      = 1 << (IN_P_DW_BYTES - OUT_P_DW_BYTES);
  localparam int unsigned IDXW   = (N > 1) ? $clog2(N) : 1;

  // Clears the offset-within-request bits of an address.
  localparam logic [AW-1:0] LINE_MASK = ~((AW'(1) << IN_P_DW_BYTES) - AW'(1));

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_RESP
  } state_t;

  state_t              r_state;
  logic                r_req_rdy;
  logic                r_bus_vld;
  logic [AW-1:0]       r_bus_addr;
  logic [OUT_DW-1:0]   r_bus_dat;
  logic [OUT_BE-1:0]   r_bus_be;
  logic                r_done;
  logic                r_err;

  logic [AW-1:0]       r_addr;
  logic [IN_DW-1:0]    r_dat;
  logic [IN_BE-1:0]    r_be;
  logic [IDXW-1:0]     r_idx;
  logic                r_acc;

  logic                w_first_found;
  logic [IDXW-1:0]     w_first_idx;
  logic                w_next_found;
  logic [IDXW-1:0]     w_next_idx;

  // One bit per window: set when that window has any byte enabled.
  function automatic logic [N-1:0] nz_map(input logic [IN_BE-1:0] be);
    logic [N-1:0] m;
    m = '0;
    for (int unsigned j = 0; j < N; j++) begin
      m[j] = |be[j*OUT_BE +: OUT_BE];
    end
    return m;
  endfunction

  // Lowest set window at or above start; MSB of the result is the found flag.
  function automatic logic [IDXW:0] find_win(input logic [N-1:0] m,
                                             input int unsigned start);
    logic            found;
    logic [IDXW-1:0] idx;
    found = 1'b0;
    idx   = '0;
    for (int unsigned j = 0; j < N; j++) begin
      if (!found && (j >= start) && m[j]) begin
        found = 1'b1;
        idx   = IDXW'(j);
      end
    end
    return {found, idx};
  endfunction

  // Window k of a wide data word, selected with constant slices only.
  function automatic logic [OUT_DW-1:0] win_dat(input logic [IN_DW-1:0] dat,
                                                input logic [IDXW-1:0]  k);
    logic [OUT_DW-1:0] res;
    res = '0;
    for (int unsigned j = 0; j < N; j++) begin
      if (IDXW'(j) == k) res = dat[j*OUT_DW +: OUT_DW];
    end
    return res;
  endfunction

  function automatic logic [OUT_BE-1:0] win_be(input logic [IN_BE-1:0] be,
                                               input logic [IDXW-1:0] k);
    logic [OUT_BE-1:0] res;
    res = '0;
    for (int unsigned j = 0; j < N; j++) begin
      if (IDXW'(j) == k) res = be[j*OUT_BE +: OUT_BE];
    end
    return res;
  endfunction

  // Request base with the window index placed above the beat offset.
  function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0]   addr,
                                              input logic [IDXW-1:0] k);
    return (addr & LINE_MASK) | (AW'(k) << OUT_P_DW_BYTES);
  endfunction

  // First window of an incoming request, next window of the latched one.
  assign {w_first_found, w_first_idx} = find_win(nz_map(i_req_be), 32'd0);
  assign {w_next_found,  w_next_idx}  = find_win(nz_map(r_be), 32'(r_idx) + 32'd1);

  // Sequencer: accept, issue each enabled window, collect responses, report.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_req_rdy  <= 1'b1;
      r_bus_vld  <= 1'b0;
      r_bus_addr <= '0;
      r_bus_dat  <= '0;
      r_bus_be   <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_addr     <= '0;
      r_dat      <= '0;
      r_be       <= '0;
      r_idx      <= '0;
      r_acc      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_req_vld && r_req_rdy) begin
            r_addr <= i_req_addr;
            r_dat  <= i_req_dat;
            r_be   <= i_req_be;
            r_acc  <= 1'b0;
            if (w_first_found) begin
              r_idx      <= w_first_idx;
              r_state    <= S_ISSUE;
              r_req_rdy  <= 1'b0;
              r_bus_vld  <= 1'b1;
              r_bus_addr <= beat_addr(i_req_addr, w_first_idx);
              r_bus_dat  <= win_dat(i_req_dat, w_first_idx);
              r_bus_be   <= win_be(i_req_be, w_first_idx);
            end else begin
              // Nothing enabled: complete immediately without a beat.
              r_done <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (i_bus_rdy) begin
            r_bus_vld <= 1'b0;
            r_state   <= S_WAIT_RESP;
          end
        end
        S_WAIT_RESP: begin
          if (i_bus_bvld) begin
            r_acc <= r_acc | i_bus_berr;
            if (w_next_found) begin
              r_idx      <= w_next_idx;
              r_state    <= S_ISSUE;
              r_bus_vld  <= 1'b1;
              r_bus_addr <= beat_addr(r_addr, w_next_idx);
              r_bus_dat  <= win_dat(r_dat, w_next_idx);
              r_bus_be   <= win_be(r_be, w_next_idx);
            end else begin
              r_state   <= S_IDLE;
              r_req_rdy <= 1'b1;
              r_done    <= 1'b1;
              r_err     <= r_acc | i_bus_berr;
            end
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_req_rdy <= 1'b1;
          r_bus_vld <= 1'b0;
        end
      endcase
    end
  end

  assign o_req_rdy  = r_req_rdy;
  assign o_bus_vld  = r_bus_vld;
  assign o_bus_addr = r_bus_addr;
  assign o_bus_dat  = r_bus_dat;
  assign o_bus_be   = r_bus_be;
  assign o_done     = r_done;
  assign o_err      = r_err;

endmodule

// File: tb/tb_wr_beat_seq.sv
// Testbench for wr_beat_seq at default widths (8 B requests, 4 B beats).
module tb_wr_beat_seq;

  localparam int unsigned AW  = 32;
  localparam int unsigned NW  = 2;
  localparam int unsigned OBE = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req_vld = 1'b0;
  logic        o_req_rdy;
  logic [31:0] i_req_addr = '0;
  logic [63:0] i_req_dat = '0;
  logic [7:0]  i_req_be = '0;
  logic        o_bus_vld;
  logic        i_bus_rdy = 1'b0;
  logic [31:0] o_bus_addr;
  logic [31:0] o_bus_dat;
  logic [3:0]  o_bus_be;
  logic        i_bus_bvld = 1'b0;
  logic        i_bus_berr = 1'b0;
  logic        o_done;
  logic        o_err;

  int checks = 0;
  int errors = 0;

  wr_beat_seq #(.IN_P_DW_BYTES(3), .OUT_P_DW_BYTES(2), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_vld(i_req_vld), .o_req_rdy(o_req_rdy),
    .i_req_addr(i_req_addr), .i_req_dat(i_req_dat), .i_req_be(i_req_be),
    .o_bus_vld(o_bus_vld), .i_bus_rdy(i_bus_rdy),
    .o_bus_addr(o_bus_addr), .o_bus_dat(o_bus_dat), .o_bus_be(o_bus_be),
    .i_bus_bvld(i_bus_bvld), .i_bus_berr(i_bus_berr),
    .o_done(o_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] dat;
    logic [3:0]  be;
    int unsigned win;
  } beat_t;

  typedef struct {
    logic [31:0] addr;
    logic [63:0] dat;
    logic [7:0]  be;
    int unsigned stall;
    logic [1:0]  emask;
    int unsigned exp_n;
    logic [31:0] exp_a0;
    logic [31:0] exp_d0;
    logic [3:0]  exp_b0;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [63:0] d, input logic [7:0] be,
                              input int unsigned st, input logic [1:0] em, input int unsigned n,
                              input logic [31:0] a0, input logic [31:0] d0, input logic [3:0] b0,
                              input logic e);
    vec_t v;
    v.addr = a; v.dat = d; v.be = be; v.stall = st; v.emask = em;
    v.exp_n = n; v.exp_a0 = a0; v.exp_d0 = d0; v.exp_b0 = b0; v.exp_err = e;
    return v;
  endfunction

  // Runs one request starting at a negedge; returns at the negedge showing o_done.
  // Expected beats come from walking the windows of the request directly.
  task automatic do_req(input logic [31:0] addr, input logic [63:0] dat, input logic [7:0] be,
                        input int unsigned stall, input int unsigned rdly, input logic [1:0] emask,
                        input bit stray, output int unsigned nbeats, output logic [31:0] a0,
                        output logic [31:0] d0, output logic [3:0] b0, output logic err_o);
    beat_t        q[$];
    beat_t        b;
    logic         exp_err;
    logic [31:0]  base;
    logic [67:0]  held;
    bit           held_valid, pend, done;
    logic         pend_err;
    int unsigned  rcnt, stall_left;

    exp_err = 1'b0;
    base    = addr & ~32'h7;
    for (int k = 0; k < NW; k++) begin
      if (be[k*OBE +: OBE] != '0) begin
        b.addr = base + 32'(k * 4);
        b.dat  = dat[k*32 +: 32];
        b.be   = be[k*OBE +: OBE];
        b.win  = k;
        q.push_back(b);
        exp_err = exp_err | emask[k];
      end
    end

    nbeats = 0; a0 = '0; d0 = '0; b0 = '0; err_o = 1'b0;
    held = '0; held_valid = 0; pend = 0; done = 0; pend_err = 1'b0;
    rcnt = 0; stall_left = stall;

    chk("req_rdy_idle", 128'(o_req_rdy), 128'(1));
    i_req_vld  = 1'b1;
    i_req_addr = addr;
    i_req_dat  = dat;
    i_req_be   = be;
    @(negedge clk);
    i_req_vld  = 1'b0;
    i_req_addr = $urandom;
    i_req_dat  = {$urandom, $urandom};
    i_req_be   = 8'($urandom);
    if (q.size() == 0) chk("empty_done_lat", 128'({o_bus_vld, o_done, o_err}), 128'(3'b010));
    else               chk("beat_lat", 128'(o_bus_vld), 128'(1));

    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      i_bus_bvld = 1'b0;
      i_bus_berr = 1'b0;
      if (o_done) begin
        chk("err", 128'(o_err), 128'(exp_err));
        chk("beats_left", 128'(q.size()), 128'(0));
        chk("rdy_done", 128'(o_req_rdy), 128'(1));
        err_o = o_err;
        i_bus_rdy = 1'b0;
        done = 1;
      end else begin
        chk("rdy_busy", 128'(o_req_rdy), 128'(0));
        if (pend) begin
          if (rcnt == 0) begin
            i_bus_bvld = 1'b1;
            i_bus_berr = pend_err;
            pend = 0;
          end else begin
            rcnt--;
          end
        end
        if (o_bus_vld) begin
          if (held_valid) chk("hold", 128'({o_bus_addr, o_bus_dat, o_bus_be}), 128'(held));
          if (q.size() == 0) begin
            chk("extra_beat", 128'(o_bus_vld), 128'(0));
            i_bus_rdy = 1'b1;
          end else begin
            chk("baddr", 128'(o_bus_addr), 128'(q[0].addr));
            chk("bdat", 128'(o_bus_dat), 128'(q[0].dat));
            chk("bbe", 128'(o_bus_be), 128'(q[0].be));
            if (nbeats == 0) begin
              a0 = o_bus_addr; d0 = o_bus_dat; b0 = o_bus_be;
            end
            // Responses outside WAIT_RESP must be ignored.
            if (stray && $urandom_range(0, 1) == 1) begin
              i_bus_bvld = 1'b1;
              i_bus_berr = 1'b1;
            end
            if (nbeats == 0 && stall_left > 0) begin
              i_bus_rdy  = 1'b0;
              stall_left--;
              held       = {o_bus_addr, o_bus_dat, o_bus_be};
              held_valid = 1;
            end else begin
              i_bus_rdy  = 1'b1;
              pend       = 1;
              rcnt       = rdly;
              pend_err   = emask[q[0].win];
              void'(q.pop_front());
              nbeats++;
              held_valid = 0;
            end
          end
        end else begin
          i_bus_rdy  = 1'($urandom_range(0, 1));
          held_valid = 0;
        end
        @(negedge clk);
      end
    end
    chk("timeout", 128'(done), 128'(1));
  endtask

  vec_t        vt[10];
  int unsigned nb;
  logic [31:0] a0, d0;
  logic [3:0]  b0;
  logic        eo;
  logic [63:0] rd;
  logic [7:0]  rbe;
  logic [63:0] D;

  initial begin
    D = 64'h1122334455667788;
    vt[0] = mk(32'h1000, D, 8'hFF, 0, 2'b00, 2, 32'h1000, 32'h55667788, 4'hF, 1'b0);
    vt[1] = mk(32'h1000, D, 8'hC0, 0, 2'b00, 1, 32'h1004, 32'h11223344, 4'hC, 1'b0);
    vt[2] = mk(32'h1000, D, 8'h03, 0, 2'b00, 1, 32'h1000, 32'h55667788, 4'h3, 1'b0);
    vt[3] = mk(32'h1000, D, 8'h00, 0, 2'b11, 0, 32'h0,    32'h0,        4'h0, 1'b0);
    vt[4] = mk(32'h1000, D, 8'hFF, 5, 2'b00, 2, 32'h1000, 32'h55667788, 4'hF, 1'b0);
    vt[5] = mk(32'h1000, D, 8'hFF, 0, 2'b01, 2, 32'h1000, 32'h55667788, 4'hF, 1'b1);
    vt[6] = mk(32'h1000, D, 8'hFF, 0, 2'b00, 2, 32'h1000, 32'h55667788, 4'hF, 1'b0);
    vt[7] = mk(32'h2007, D, 8'hF0, 0, 2'b00, 1, 32'h2004, 32'h11223344, 4'hF, 1'b0);
    vt[8] = mk(32'h200C, D, 8'h0F, 0, 2'b10, 1, 32'h2008, 32'h55667788, 4'hF, 1'b0);
    vt[9] = mk(32'h3000, D, 8'h81, 2, 2'b10, 2, 32'h3000, 32'h55667788, 4'h1, 1'b1);

    // Reset state.
    #2;
    chk("rst_vld", 128'(o_bus_vld), 128'(0));
    chk("rst_done_err", 128'({o_done, o_err}), 128'(0));
    chk("rst_bus", 128'({o_bus_addr, o_bus_dat, o_bus_be}), 128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rdy", 128'(o_req_rdy), 128'(1));

    // Directed vectors, issued back to back (next accept in the done cycle).
    for (int i = 0; i < 10; i++) begin
      do_req(vt[i].addr, vt[i].dat, vt[i].be, vt[i].stall, 2, vt[i].emask, 1'b0,
             nb, a0, d0, b0, eo);
      chk($sformatf("v%0d_nbeats", i), 128'(nb), 128'(vt[i].exp_n));
      if (vt[i].exp_n > 0) begin
        chk($sformatf("v%0d_a0", i), 128'(a0), 128'(vt[i].exp_a0));
        chk($sformatf("v%0d_d0", i), 128'(d0), 128'(vt[i].exp_d0));
        chk($sformatf("v%0d_b0", i), 128'(b0), 128'(vt[i].exp_b0));
      end
      chk($sformatf("v%0d_err", i), 128'(eo), 128'(vt[i].exp_err));
    end

    // Reset while a beat is being offered: outputs clear without a clock edge.
    @(negedge clk);
    i_req_vld = 1'b1; i_req_addr = 32'h4000; i_req_dat = D; i_req_be = 8'hFF;
    i_bus_rdy = 1'b0;
    @(negedge clk);
    i_req_vld = 1'b0;
    chk("mo_issue_vld", 128'(o_bus_vld), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("mo_issue_rst_vld", 128'(o_bus_vld), 128'(0));
    chk("mo_issue_rst_bus", 128'({o_bus_addr, o_bus_dat, o_bus_be}), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset while waiting for a response, then a stray response afterwards.
    i_req_vld = 1'b1; i_req_addr = 32'h5000; i_req_dat = D; i_req_be = 8'hFF;
    @(negedge clk);
    i_req_vld = 1'b0;
    i_bus_rdy = 1'b1;
    @(negedge clk);
    i_bus_rdy = 1'b0;
    chk("mo_wait_vld", 128'({o_bus_vld, o_req_rdy}), 128'(0));
    #2 rst_n = 1'b0;
    #1;
    chk("mo_wait_rst", 128'({o_bus_vld, o_done, o_err}), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    i_bus_bvld = 1'b1; i_bus_berr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stray_ign", 128'({o_req_rdy, o_bus_vld, o_done, o_err}), 128'(4'b1000));
    end
    i_bus_bvld = 1'b0; i_bus_berr = 1'b0;
    do_req(32'h6000, D, 8'hFF, 0, 1, 2'b00, 1'b0, nb, a0, d0, b0, eo);
    chk("post_rst_nbeats", 128'(nb), 128'(2));
    chk("post_rst_err", 128'(eo), 128'(0));

    // Randomized requests against the window model.
    for (int i = 0; i < 60; i++) begin
      rd = {$urandom, $urandom};
      case ($urandom_range(0, 9))
        0:       rbe = 8'h00;
        1:       rbe = 8'hFF;
        default: rbe = 8'($urandom);
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_req($urandom, rd, rbe, $urandom_range(0, 3), $urandom_range(0, 3),
             2'($urandom), 1'b1, nb, a0, d0, b0, eo);
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/wr_beat_seq.md
Name: wr_beat_seq

Overview:
- Write-path sequencer that takes one wide write request (upstream data width) and issues it as a series of narrow beats on a narrower write bus.
- Only windows with a non-zero byte-enable produce a beat; windows are issued in ascending address order.
- Exactly one beat is outstanding at a time, and each beat waits for its write response.
- Sits between a wide-datapath master (cache write-back or store buffer) and a narrow memory/peripheral write port. It is the sequencing counterpart of the write-alignment datapath.

Parameters:
- IN_P_DW_BYTES, 3, log2 of upstream request width in bytes (default 8 B). Must satisfy IN_P_DW_BYTES >= OUT_P_DW_BYTES.
- OUT_P_DW_BYTES, 2, log2 of bus beat width in bytes (default 4 B).
- AW, 32, address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- i_req_vld  in  1  request valid
- o_req_rdy  out  1  request ready
- i_req_addr  in  AW  request address; bits [IN_P_DW_BYTES-1:0] ignored
- i_req_dat  in  (1<<IN_P_DW_BYTES)*8  request write data
- i_req_be  in  (1<<IN_P_DW_BYTES)  request byte enables
- o_bus_vld  out  1  beat valid
- i_bus_rdy  in  1  beat ready
- o_bus_addr  out  AW  beat address
- o_bus_dat  out  (1<<OUT_P_DW_BYTES)*8  beat data
- o_bus_be  out  (1<<OUT_P_DW_BYTES)  beat byte enables
- i_bus_bvld  in  1  write response valid
- i_bus_berr  in  1  write response error, qualified by i_bus_bvld
- o_done  out  1  one-cycle pulse: request complete
- o_err  out  1  OR of all beat errors for the request; valid while o_done=1, otherwise 0

Behaviour:
- Window count is N = 1<<(IN_P_DW_BYTES-OUT_P_DW_BYTES). Window k covers data bits [k*W +: W] and be bits [k*W/8 +: W/8], where W = (1<<OUT_P_DW_BYTES)*8.
- States are IDLE, ISSUE and WAIT_RESP. All outputs are registered.
- Reset (asynchronous, and also mid-operation) forces state=IDLE and clears o_bus_vld, o_bus_addr, o_bus_dat, o_bus_be, o_done and o_err. Any in-flight request is abandoned. o_req_rdy=1 once reset is released.
- o_req_rdy=1 only in IDLE.
- IDLE:
  - On i_req_vld&&o_req_rdy, latch addr, dat and be, and clear the error accumulator.
  - If the lowest window with non-zero be exists, set idx to it, go to ISSUE, and raise o_bus_vld in the next cycle (accept-to-beat latency 1).
  - If be==0, stay in IDLE and pulse o_done the next cycle with o_err=0. No bus beat is issued.
- ISSUE:
  - o_bus_vld=1.
  - o_bus_addr = {addr[AW-1:IN_P_DW_BYTES], idx, OUT_P_DW_BYTES zero bits}.
  - o_bus_dat and o_bus_be are window idx of the latched data and be.
  - All beat outputs stay stable while i_bus_rdy=0.
  - On i_bus_rdy, drop o_bus_vld and go to WAIT_RESP.
- WAIT_RESP:
  - i_bus_bvld is sampled only in this state; responses in other states are ignored.
  - On i_bus_bvld, OR i_bus_berr into the accumulator.
  - If a higher window with non-zero be remains, set idx to the next such window and go to ISSUE (o_bus_vld in the next cycle).
  - Otherwise go to IDLE, pulse o_done for one cycle, and drive o_err with the accumulated value.
- A new request can be accepted in the same cycle that o_done is high, since o_req_rdy is 1 in IDLE.
- Windows with be==0 in the middle of a request are skipped, with no idle beat issued for them.
- An error does not abort the sequence; the remaining beats are still issued.
- When IN_P_DW_BYTES==OUT_P_DW_BYTES, N=1 and the block issues a single beat.
- Outputs in IDLE: o_bus_vld=0. o_bus_addr, o_bus_dat and o_bus_be hold their last values; these are don't-care.

Test Plan (defaults: 8 B request, 4 B beats):
- Full write: addr=0x1000, be=0xFF, dat=0x1122334455667788, rdy=1, bvld 2 cycles after each beat → beats (0x1000, 0x55667788, 0xF) then (0x1004, 0x11223344, 0xF). o_done pulses once with o_err=0. o_req_rdy=0 from accept until done.
- Sparse: be=0xC0, same addr and data → single beat addr=0x1004, be=0xC, dat=0x11223344. be=0x03 → single beat addr=0x1000, be=0x3.
- Empty: be=0x00 → no o_bus_vld. o_done=1 in the cycle after accept with o_err=0.
- Backpressure: i_bus_rdy low for 5 cycles on beat 0 → o_bus_vld, addr, dat and be held constant for all 5 cycles. Beat 1 follows normally afterwards.
- Error: i_bus_berr=1 on beat 0 response, 0 on beat 1 → beat 1 is still issued, and o_err=1 with o_done. A following clean request reports o_err=0.
- Reset mid-op: assert rst_n=0 in WAIT_RESP → o_bus_vld=0, o_done=0, o_err=0 immediately. After release o_req_rdy=1, and a stray i_bus_bvld is ignored.
